// File: rtl/mos6502_interrupt_sequencer.sv
// mos6502_interrupt_sequencer
//   Sequences the 7-cycle 6502 interrupt/BRK/RESET entry: dummy read, three stack
//   pushes (PCH, PCL, P), then two vector fetches into PCL/PCH.
// Ports:
//   clk, nRESET (sync, active-low), clk_en (CPU cycle enable)
//   SYNC, OP_BRK          opcode-fetch qualifier and BRK decode
//   nNMI_req, nIRQ_req    active-low requests; SO_req active-high set-overflow
//   PC, P, SP             current CPU registers
//   ACTIVE, ADDR, DOUT, RnW                bus view of the sequence
//   SP_DEC, PCL_LOAD, PCH_LOAD, SET_I, SET_V, NMI_ACK   clk_en-qualified strobes
//   VEC                   0=none, 1=NMI, 2=RESET, 3=IRQ/BRK
module mos6502_interrupt_sequencer (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        clk_en,
  input  logic        SYNC,
  input  logic        OP_BRK,
  input  logic        nNMI_req,
  input  logic        nIRQ_req,
  input  logic        SO_req,
  input  logic [15:0] PC,
  input  logic [7:0]  P,
  input  logic [7:0]  SP,
  output logic        ACTIVE,
  output logic [15:0] ADDR,
  output logic [7:0]  DOUT,
  output logic        RnW,
  output logic        SP_DEC,
  output logic        PCL_LOAD,
  output logic        PCH_LOAD,
  output logic        SET_I,
  output logic        SET_V,
  output logic        NMI_ACK,
  output logic [1:0]  VEC
);

  typedef enum logic [2:0] {StIdle, St2, St3, St4, St5, St6, St7} state_e;

  localparam logic [1:0] VecNone = 2'd0;
  localparam logic [1:0] VecNmi  = 2'd1;
  localparam logic [1:0] VecRst  = 2'd2;
  localparam logic [1:0] VecIrq  = 2'd3;

  state_e     r_state, w_state_d;
  logic [1:0] r_src, w_src_d;
  logic       r_brk, w_brk_d;

  logic [15:0] w_stack;
  logic [15:0] w_vbase;
  logic        w_sp_dec, w_pcl, w_pch, w_seti, w_nack;
  logic        w_push_rnw;

  always_ff @(posedge clk) begin
    r_state <= w_state_d;
    r_src   <= w_src_d;
    r_brk   <= w_brk_d;
  end

  // Next state. Reset wins over clk_en so a stalled CPU still restarts.
  always_comb begin
    w_state_d = r_state;
    w_src_d   = r_src;
    w_brk_d   = r_brk;
    if (!nRESET) begin
      w_state_d = St2;
      w_src_d   = VecRst;
      w_brk_d   = 1'b0;
    end else if (clk_en) begin
      case (r_state)
        StIdle: begin
          if (SYNC) begin
            if (!nNMI_req) begin
              w_state_d = St2;
              w_src_d   = VecNmi;
              w_brk_d   = 1'b0;
            end else if (!nIRQ_req) begin
              w_state_d = St2;
              w_src_d   = VecIrq;
              w_brk_d   = 1'b0;
            end else if (OP_BRK) begin
              w_state_d = St2;
              w_src_d   = VecIrq;
              w_brk_d   = 1'b1;
            end
          end
        end
        St2:     w_state_d = St3;
        St3:     w_state_d = St4;
        St4:     w_state_d = St5;
        St5:     w_state_d = St6;
        St6:     w_state_d = St7;
        St7:     w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
      // NMI hijack: redirect the vector only; the latched B bit is kept.
      if ((r_state == St2 || r_state == St3 || r_state == St4 || r_state == St5) &&
          r_src == VecIrq && !nNMI_req) begin
        w_src_d = VecNmi;
      end
    end
  end

  assign w_stack = {8'h01, SP};

  always_comb begin
    case (r_src)
      VecNmi:  w_vbase = 16'hFFFA;
      VecRst:  w_vbase = 16'hFFFC;
      default: w_vbase = 16'hFFFE;
    endcase
  end

  // Reset sequence walks the stack with reads only.
  assign w_push_rnw = (r_src == VecRst);

  always_comb begin
    ACTIVE   = (r_state != StIdle);
    VEC      = (r_state != StIdle) ? r_src : VecNone;
    ADDR     = PC;
    DOUT     = 8'h00;
    RnW      = 1'b1;
    w_sp_dec = 1'b0;
    w_pcl    = 1'b0;
    w_pch    = 1'b0;
    w_seti   = 1'b0;
    w_nack   = 1'b0;
    case (r_state)
      St3: begin
        ADDR     = w_stack;
        DOUT     = PC[15:8];
        RnW      = w_push_rnw;
        w_sp_dec = 1'b1;
      end
      St4: begin
        ADDR     = w_stack;
        DOUT     = PC[7:0];
        RnW      = w_push_rnw;
        w_sp_dec = 1'b1;
      end
      St5: begin
        ADDR     = w_stack;
        DOUT     = {P[7:6], 1'b1, r_brk, P[3:0]};
        RnW      = w_push_rnw;
        w_sp_dec = 1'b1;
      end
      St6: begin
        ADDR   = w_vbase;
        w_pcl  = 1'b1;
        w_seti = 1'b1;
        w_nack = (r_src == VecNmi);
      end
      St7: begin
        ADDR  = {w_vbase[15:1], 1'b1};
        w_pch = 1'b1;
      end
      default: ;
    endcase
    if (!nRESET) begin
      ACTIVE   = 1'b1;
      VEC      = VecRst;
      ADDR     = PC;
      DOUT     = 8'h00;
      RnW      = 1'b1;
      w_sp_dec = 1'b0;
      w_pcl    = 1'b0;
      w_pch    = 1'b0;
      w_seti   = 1'b0;
      w_nack   = 1'b0;
    end
  end

  assign SP_DEC   = w_sp_dec & clk_en;
  assign PCL_LOAD = w_pcl & clk_en;
  assign PCH_LOAD = w_pch & clk_en;
  assign SET_I    = w_seti & clk_en;
  assign NMI_ACK  = w_nack & clk_en;
  assign SET_V    = SO_req & clk_en & nRESET;

endmodule

// File: tb/tb_mos6502_interrupt_sequencer.sv
module tb_mos6502_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        nRESET, clk_en, SYNC, OP_BRK, nNMI_req, nIRQ_req, SO_req;
  logic [15:0] PC;
  logic [7:0]  P, SP;
  logic        ACTIVE, RnW, SP_DEC, PCL_LOAD, PCH_LOAD, SET_I, SET_V, NMI_ACK;
  logic [15:0] ADDR;
  logic [7:0]  DOUT;
  logic [1:0]  VEC;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [9:0]  ctl;
  } exp_t;

  exp_t sb[$];

  // Strobe bits cleared when clk_en=0; ACTIVE, RnW and VEC are kept.
  localparam logic [9:0] CeMask = 10'b11_0000_0011;

  always #5 clk = ~clk;

  mos6502_interrupt_sequencer dut (
    .clk      (clk),
    .nRESET   (nRESET),
    .clk_en   (clk_en),
    .SYNC     (SYNC),
    .OP_BRK   (OP_BRK),
    .nNMI_req (nNMI_req),
    .nIRQ_req (nIRQ_req),
    .SO_req   (SO_req),
    .PC       (PC),
    .P        (P),
    .SP       (SP),
    .ACTIVE   (ACTIVE),
    .ADDR     (ADDR),
    .DOUT     (DOUT),
    .RnW      (RnW),
    .SP_DEC   (SP_DEC),
    .PCL_LOAD (PCL_LOAD),
    .PCH_LOAD (PCH_LOAD),
    .SET_I    (SET_I),
    .SET_V    (SET_V),
    .NMI_ACK  (NMI_ACK),
    .VEC      (VEC)
  );

  // Control word: {ACTIVE, RnW, SP_DEC, PCL_LOAD, PCH_LOAD, SET_I, SET_V, NMI_ACK, VEC}
  function automatic logic [9:0] c(input logic act, input logic rnw, input logic spd,
                                   input logic pcl, input logic pch, input logic seti,
                                   input logic setv, input logic nack, input logic [1:0] vec);
    return {act, rnw, spd, pcl, pch, seti, setv, nack, vec};
  endfunction

  task automatic push(input string tag, input logic [15:0] a, input logic [7:0] d,
                      input logic [9:0] ctl);
    exp_t e;
    e.tag  = tag;
    e.addr = a;
    e.dout = d;
    e.ctl  = ctl;
    sb.push_back(e);
  endtask

  // Compare one cycle at the falling edge, then advance past the rising edge and
  // apply the modelled stack-pointer decrement.
  task automatic step();
    exp_t       e;
    logic [9:0] obs;
    logic       dec;
    dec = 1'b0;
    @(negedge clk);
    obs = {ACTIVE, RnW, SP_DEC, PCL_LOAD, PCH_LOAD, SET_I, SET_V, NMI_ACK, VEC};
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_underflow got empty queue want entry");
    end else begin
      e   = sb.pop_front();
      dec = e.ctl[7];
      checks++;
      assert (ADDR === e.addr) else begin
        errors++;
        $error("FAIL %s addr got %h want %h", e.tag, ADDR, e.addr);
      end
      checks++;
      assert (DOUT === e.dout) else begin
        errors++;
        $error("FAIL %s dout got %h want %h", e.tag, DOUT, e.dout);
      end
      checks++;
      assert (obs === e.ctl) else begin
        errors++;
        $error("FAIL %s ctl got %b want %b", e.tag, obs, e.ctl);
      end
    end
    @(posedge clk);
    #1;
    if (dec) SP = SP - 8'd1;
  endtask

  // Same bus cycle twice: first with clk_en=0 (strobes masked), then clk_en=1.
  task automatic dual(input string tag, input logic [15:0] a, input logic [7:0] d,
                      input logic [9:0] ctl);
    clk_en = 1'b0;
    push({tag, "_ce0"}, a, d, ctl & CeMask);
    step();
    clk_en = 1'b1;
    push({tag, "_ce1"}, a, d, ctl);
    step();
  endtask

  initial begin
    nRESET = 1'b0; clk_en = 1'b1; SYNC = 1'b0; OP_BRK = 1'b0;
    nNMI_req = 1'b1; nIRQ_req = 1'b1; SO_req = 1'b0;
    PC = 16'hC0A5; P = 8'h00; SP = 8'h00;

    // Reset hold and reset sequence (reads only, stack address wraps in page 1)
    push("rst_hold0", 16'hC0A5, 8'h00, c(1, 1, 0, 0, 0, 0, 0, 0, 2)); step();
    push("rst_hold1", 16'hC0A5, 8'h00, c(1, 1, 0, 0, 0, 0, 0, 0, 2)); step();
    nRESET = 1'b1;
    push("rst_s2", 16'hC0A5, 8'h00, c(1, 1, 0, 0, 0, 0, 0, 0, 2)); step();
    push("rst_s3", 16'h0100, 8'hC0, c(1, 1, 1, 0, 0, 0, 0, 0, 2)); step();
    push("rst_s4", 16'h01FF, 8'hA5, c(1, 1, 1, 0, 0, 0, 0, 0, 2)); step();
    push("rst_s5", 16'h01FE, 8'h20, c(1, 1, 1, 0, 0, 0, 0, 0, 2)); step();
    push("rst_s6", 16'hFFFC, 8'h00, c(1, 1, 0, 1, 0, 1, 0, 0, 2)); step();
    push("rst_s7", 16'hFFFD, 8'h00, c(1, 1, 0, 0, 1, 0, 0, 0, 2)); step();
    push("rst_idle", 16'hC0A5, 8'h00, c(0, 1, 0, 0, 0, 0, 0, 0, 0)); step();

    // IRQ with SO_req pulse during S3
    PC = 16'h1234; SP = 8'hFF; P = 8'h00; SYNC = 1'b1; nIRQ_req = 1'b0;
    push("irq_idle", 16'h1234, 8'h00, c(0, 1, 0, 0, 0, 0, 0, 0, 0)); step();
    SYNC = 1'b0; nIRQ_req = 1'b1;
    push("irq_s2", 16'h1234, 8'h00, c(1, 1, 0, 0, 0, 0, 0, 0, 3)); step();
    SO_req = 1'b1;
    push("irq_s3", 16'h01FF, 8'h12, c(1, 0, 1, 0, 0, 0, 1, 0, 3)); step();
    SO_req = 1'b0;
    push("irq_s4", 16'h01FE, 8'h34, c(1, 0, 1, 0, 0, 0, 0, 0, 3)); step();
    push("irq_s5", 16'h01FD, 8'h20, c(1, 0, 1, 0, 0, 0, 0, 0, 3)); step();
    push("irq_s6", 16'hFFFE, 8'h00, c(1, 1, 0, 1, 0, 1, 0, 0, 3)); step();
    push("irq_s7", 16'hFFFF, 8'h00, c(1, 1, 0, 0, 1, 0, 0, 0, 3)); step();
    push("irq_idle2", 16'h1234, 8'h00, c(0, 1, 0, 0, 0, 0, 0, 0, 0)); step();

    // BRK, with a stray SYNC+IRQ mid-sequence that must be ignored
    PC = 16'h2000; SP = 8'h80; P = 8'h01; SYNC = 1'b1; OP_BRK = 1'b1;
    push("brk_idle", 16'h2000, 8'h00, c(0, 1, 0, 0, 0, 0, 0, 0, 0)); step();
    SYNC = 1'b0; OP_BRK = 1'b0;
    push("brk_s2", 16'h2000, 8'h00, c(1, 1, 0, 0, 0, 0, 0, 0, 3)); step();
    SYNC = 1'b1; nIRQ_req = 1'b0;
    push("brk_s3", 16'h0180, 8'h20, c(1, 0, 1, 0, 0, 0, 0, 0, 3)); step();
    push("brk_s4", 16'h017F, 8'h00, c(1, 0, 1, 0, 0, 0, 0, 0, 3)); step();
    push("brk_s5", 16'h017E, 8'h31, c(1, 0, 1, 0, 0, 0, 0, 0, 3)); step();
    SYNC = 1'b0; nIRQ_req = 1'b1;
    push("brk_s6", 16'hFFFE, 8'h00, c(1, 1, 0, 1, 0, 1, 0, 0, 3)); step();
    push("brk_s7", 16'hFFFF, 8'h00, c(1, 1, 0, 0, 1, 0, 0, 0, 3)); step();
    push("brk_idle2", 16'h2000, 8'h00, c(0, 1, 0, 0, 0, 0, 0, 0, 0)); step();

    // BRK hijacked by NMI during S4
    PC = 16'h3456; SP = 8'h40; P = 8'h00; SYNC = 1'b1; OP_BRK = 1'b1;
    push("hj_idle", 16'h3456, 8'h00, c(0, 1, 0, 0, 0, 0, 0, 0, 0)); step();
    SYNC = 1'b0; OP_BRK = 1'b0;
    push("hj_s2", 16'h3456, 8'h00, c(1, 1, 0, 0, 0, 0, 0, 0, 3)); step();
    push("hj_s3", 16'h0140, 8'h34, c(1, 0, 1, 0, 0, 0, 0, 0, 3)); step();
    nNMI_req = 1'b0;
    push("hj_s4", 16'h013F, 8'h56, c(1, 0, 1, 0, 0, 0, 0, 0, 3)); step();
    nNMI_req = 1'b1;
    push("hj_s5", 16'h013E, 8'h30, c(1, 0, 1, 0, 0, 0, 0, 0, 1)); step();
    push("hj_s6", 16'hFFFA, 8'h00, c(1, 1, 0, 1, 0, 1, 0, 1, 1)); step();
    push("hj_s7", 16'hFFFB, 8'h00, c(1, 1, 0, 0, 1, 0, 0, 0, 1)); step();
    push("hj_idle2", 16'h3456, 8'h00, c(0, 1, 0, 0, 0, 0, 0, 0, 0)); step();

    // NMI beats IRQ; clk_en alternating holds state and masks strobes
    PC = 16'hABCD; SP = 8'h20; P = 8'hC3; SYNC = 1'b1; nNMI_req = 1'b0; nIRQ_req = 1'b0;
    push("nmi_idle", 16'hABCD, 8'h00, c(0, 1, 0, 0, 0, 0, 0, 0, 0)); step();
    SYNC = 1'b0; nNMI_req = 1'b1; nIRQ_req = 1'b1;
    dual("nmi_s2", 16'hABCD, 8'h00, c(1, 1, 0, 0, 0, 0, 0, 0, 1));
    dual("nmi_s3", 16'h0120, 8'hAB, c(1, 0, 1, 0, 0, 0, 0, 0, 1));
    dual("nmi_s4", 16'h011F, 8'hCD, c(1, 0, 1, 0, 0, 0, 0, 0, 1));
    dual("nmi_s5", 16'h011E, 8'hE3, c(1, 0, 1, 0, 0, 0, 0, 0, 1));
    dual("nmi_s6", 16'hFFFA, 8'h00, c(1, 1, 0, 1, 0, 1, 0, 1, 1));
    dual("nmi_s7", 16'hFFFB, 8'h00, c(1, 1, 0, 0, 1, 0, 0, 0, 1));
    push("nmi_idle2", 16'hABCD, 8'h00, c(0, 1, 0, 0, 0, 0, 0, 0, 0)); step();

    // Reset during S4 of an IRQ cancels the pushes; SO_req right after release
    PC = 16'h5678; SP = 8'hFF; P = 8'h00; SYNC = 1'b1; nIRQ_req = 1'b0;
    push("mr_idle", 16'h5678, 8'h00, c(0, 1, 0, 0, 0, 0, 0, 0, 0)); step();
    SYNC = 1'b0; nIRQ_req = 1'b1;
    push("mr_s2", 16'h5678, 8'h00, c(1, 1, 0, 0, 0, 0, 0, 0, 3)); step();
    push("mr_s3", 16'h01FF, 8'h56, c(1, 0, 1, 0, 0, 0, 0, 0, 3)); step();
    nRESET = 1'b0;
    push("mr_rst", 16'h5678, 8'h00, c(1, 1, 0, 0, 0, 0, 0, 0, 2)); step();
    nRESET = 1'b1; SO_req = 1'b1;
    push("mr_s2r", 16'h5678, 8'h00, c(1, 1, 0, 0, 0, 0, 1, 0, 2)); step();
    SO_req = 1'b0;
    push("mr_s3r", 16'h01FE, 8'h56, c(1, 1, 1, 0, 0, 0, 0, 0, 2)); step();
    push("mr_s4r", 16'h01FD, 8'h78, c(1, 1, 1, 0, 0, 0, 0, 0, 2)); step();
    push("mr_s5r", 16'h01FC, 8'h20, c(1, 1, 1, 0, 0, 0, 0, 0, 2)); step();
    push("mr_s6r", 16'hFFFC, 8'h00, c(1, 1, 0, 1, 0, 1, 0, 0, 2)); step();
    push("mr_s7r", 16'hFFFD, 8'h00, c(1, 1, 0, 0, 1, 0, 0, 0, 2)); step();
    push("mr_idle2", 16'h5678, 8'h00, c(0, 1, 0, 0, 0, 0, 0, 0, 0)); step();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain got %0d entries want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
